mult32_control: RTL and testbench

//  Moore FSM controller for the 32-bit shift-and-add multiplier datapath
//  (multiplicand reg, product/multiplier reg, 32-bit adder, bitwise gate arrays).

---
 rtl/mult32_control.sv | 94 +++++++++
 tb/tb_mult32_control.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult32_control.sv
// mult32_control: Moore FSM sequencing a shift-and-add multiplier datapath.
// Issues load/add/shift strobes, tracks iterations, pulses done when finished.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     operation request, only honoured in IDLE
//   lsb       bit 0 of the product/multiplier register
//   load      load operands, clear product upper half
//   add_en    add multiplicand into product upper half
//   shift_en  logical shift right of the product register
//   busy      high in every state except IDLE
//   done      one-cycle pulse, product valid
//   iter_cnt  completed iterations, 0..WIDTH
module mult32_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lsb,
    output logic             load,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state;

    // State and iteration counter are the only flops; the counter
    // advances in SHIFT, so the final SHIFT leaves it at WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    iter_cnt <= '0;
                    state    <= CHECK;
                end
                CHECK: begin
                    state <= lsb ? ADD : SHIFT;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    iter_cnt <= iter_cnt + ONE;
                    if (iter_cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        state <= CHECK;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                // Unused encodings recover to IDLE.
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode: strobes depend on state only, so at most one is high.
    assign load     = (state == LOAD);
    assign add_en   = (state == ADD);
    assign shift_en = (state == SHIFT);
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mult32_control.sv
// tb_mult32_control: scoreboard bench for mult32_control with a
// behavioural shift-and-add datapath driving lsb.
module tb_mult32_control;

    logic       clk;
    logic       reset;
    logic       start;
    logic       lsb;
    logic       load;
    logic       add_en;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [5:0] iter_cnt;

    mult32_control #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lsb      (lsb),
        .load     (load),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // lsb source: 0 -> constant 0, 1 -> constant 1, 2 -> datapath model
    logic [1:0]  mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mc;
    logic [63:0] prod;
    logic        cy;

    assign lsb = (mode == 2'd2) ? prod[0] : mode[0];

    always @(posedge clk) begin
        if (load) begin
            mc   <= op_a;
            prod <= {32'h0, op_b};
            cy   <= 1'b0;
        end else if (add_en) begin
            {cy, prod[63:32]} <= {1'b0, prod[63:32]} + {1'b0, mc};
        end else if (shift_en) begin
            prod <= {cy, prod[63:1]};
            cy   <= 1'b0;
        end
    end

    typedef struct {
        int          lat;
        int          adds;
        int          shifts;
        bit          chk_prod;
        logic [63:0] prod;
        bit          gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Hand-derived: LOAD->DONE spacing is 1 + 2*32 + ones.
    task automatic expect_op(input int ones, input bit chk,
                             input logic [63:0] p, input bit gap);
        exp_t x;
        x.lat      = 65 + ones;
        x.adds     = ones;
        x.shifts   = 32;
        x.chk_prod = chk;
        x.prod     = p;
        x.gap      = gap;
        sb.push_back(x);
    endtask

    // Monitor
    int t_load;
    int t_prev_done;
    int n_add;
    int n_sh;
    bit bad;
    bit was_done;

    always @(negedge clk) begin
        if (reset) begin
            was_done = 1'b0;
        end else begin
            if (was_done) begin
                cmp("idle_after_done",
                    {58'h0, load, add_en, shift_en, busy, done}, 64'h0);
                cmp("cnt_held", {58'h0, iter_cnt}, 64'd32);
                was_done = 1'b0;
            end
            if (load) begin
                t_load = cyc;
                n_add  = 0;
                n_sh   = 0;
                bad    = 1'b0;
            end
            if (add_en)   n_add++;
            if (shift_en) n_sh++;
            if ($countones({load, add_en, shift_en, done}) > 1)
                bad = 1'b1;
            if (!busy && (load | add_en | shift_en | done))
                bad = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    cmp("latency", 64'(cyc - t_load), 64'(e.lat));
                    cmp("add_count", 64'(n_add), 64'(e.adds));
                    cmp("shift_count", 64'(n_sh), 64'(e.shifts));
                    cmp("done_cnt", {58'h0, iter_cnt}, 64'd32);
                    cmp("done_busy", {63'h0, busy}, 64'd1);
                    cmp("onehot", {63'h0, bad}, 64'd0);
                    if (e.chk_prod)
                        cmp("product", prod, e.prod);
                    if (e.gap)
                        cmp("b2b_gap", 64'(t_load - t_prev_done), 64'd2);
                end
                t_prev_done = cyc;
                was_done    = 1'b1;
            end
        end
    end

    task automatic op_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            nvec++;
            nerr++;
            $display("FAIL timeout_idle: busy %0b, pending %0d",
                     busy, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'd0;
        op_a  = '0;
        op_b  = '0;

        // Reset held with start high
        repeat (3) begin
            @(negedge clk);
            cmp("reset_outs",
                {59'h0, load, add_en, shift_en, busy, done}, 64'h0);
            cmp("reset_cnt", {58'h0, iter_cnt}, 64'h0);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        cmp("idle_outs",
            {59'h0, load, add_en, shift_en, busy, done}, 64'h0);

        // lsb always 0
        mode = 2'd0;
        expect_op(0, 1'b0, 64'h0, 1'b0);
        op_start();
        wait_idle(200);

        // lsb always 1
        mode = 2'd1;
        expect_op(32, 1'b0, 64'h0, 1'b0);
        op_start();
        wait_idle(300);

        // Full system with datapath model
        mode = 2'd2;
        op_a = 32'h0000FFFF;
        op_b = 32'h00010001;
        expect_op(2, 1'b1, 64'h00000000_FFFFFFFF, 1'b0);
        op_start();
        wait_idle(200);

        op_a = 32'hFFFFFFFF;
        op_b = 32'h00000007;
        expect_op(3, 1'b1, 64'h00000006_FFFFFFF9, 1'b0);
        op_start();
        wait_idle(200);

        // start pulses mid-operation are ignored
        mode = 2'd1;
        expect_op(32, 1'b0, 64'h0, 1'b0);
        op_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(300);
        repeat (5) begin
            @(negedge clk);
            cmp("no_restart", {63'h0, busy}, 64'h0);
        end

        // start held: three back-to-back operations
        mode = 2'd0;
        expect_op(0, 1'b0, 64'h0, 1'b0);
        expect_op(0, 1'b0, 64'h0, 1'b1);
        expect_op(0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        k = 0;
        while (k < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (done) k++;
        end
        start = 1'b0;
        if (k < 3) begin
            nvec++;
            nerr++;
            $display("FAIL timeout_b2b: dones %0d, want 3", k);
        end
        wait_idle(300);

        // Reset during ADD of iteration 10
        mode = 2'd1;
        op_start();
        n = 0;
        while (!(add_en && iter_cnt == 6'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nvec++;
            nerr++;
            $display("FAIL timeout_add10: cnt %0d, want 10", iter_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        cmp("abort_outs",
            {59'h0, load, add_en, shift_en, busy, done}, 64'h0);
        cmp("abort_cnt", {58'h0, iter_cnt}, 64'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmp("abort_idle", {62'h0, busy, done}, 64'h0);
        end

        mode = 2'd0;
        expect_op(0, 1'b0, 64'h0, 1'b0);
        op_start();
        wait_idle(200);

        repeat (3) @(negedge clk);
        cmp("sb_empty", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
